md_scheduler: RTL
=================

# md_scheduler

Multi-cycle multiply/divide scheduler for the five-stage pipeline. It accepts mult/multu/div/divu/mthi/mtlo issued from the E stage and sequences the multi-cycle operation with a cycle counter. It owns the HI/LO registers and raises a stall request that the hazard unit ORs into its global Stall, so that any D-stage instruction touching HI/LO waits until the unit is free.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1–15)
- DIV_CYCLES, 10, busy cycles for div/divu (legal range 1–15)

Ports:
- clk  input  1  pipeline clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state
- start  input  1  E-stage instruction is an MD op this cycle (already qualified by no E flush)
- md_op  input  3  operation code: MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5; 6–7 reserved
- A  input  32  forwarded RS value from E stage
- B  input  32  forwarded RT value from E stage
- md_use_D  input  1  D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
- busy  output  1  a mult/div is in progress
- stall_md  output  1  stall request to the hazard unit
- HI  output  32  HI register
- LO  output  32  LO register

## Operation
- FSM states: IDLE, BUSY. Reset -> IDLE, cnt=0, HI=0, LO=0, busy=0, stall_md=0.
- IDLE, start with MULT/MULTU/DIV/DIVU: the result is computed combinationally from A/B and latched into pend_hi/pend_lo. cnt loads MULT_CYCLES or DIV_CYCLES. Go to BUSY.
- IDLE, start with MTHI: HI<=A at the edge. MTLO: LO<=A. Stay IDLE; busy is never raised.
- IDLE, start with a reserved op: no effect.
- BUSY: cnt decrements each cycle. At the edge where cnt==1: HI<=pend_hi, LO<=pend_lo, cnt->0, go to IDLE.
- start while BUSY is a protocol violation, because the hazard unit prevents it. Requirements: ignore it, leave HI/LO/pend/cnt unchanged, and fire a simulation assertion.
- MULT: signed 32x32 -> 64-bit product. HI=product[63:32], LO=product[31:0]. MULTU: same, unsigned.
- DIV: signed. LO=quotient truncated toward zero; HI=remainder, which takes the sign of the dividend. DIVU: unsigned.
- Divisor B==0 for DIV or DIVU: the unit still goes busy for DIV_CYCLES, and HI/LO are left unchanged at completion.
- stall_md = md_use_D && (busy || (start && md_op is MULT/MULTU/DIV/DIVU)). This is combinational, with no register.
- mfhi/mflo in E read HI/LO directly. They can never see a stale value, because they were stalled in D while busy.

## Timing
- start sampled at edge t (IDLE). busy=1 for the cycles after edges t..t+N-1 (exactly N cycles, N = MULT_CYCLES or DIV_CYCLES).
- New HI/LO are visible in the cycle after edge t+N, which is also the first cycle with busy=0.
- MTHI/MTLO: the new value is visible in the cycle after the start edge (latency 1).
- stall_md is asserted in the start cycle itself and in all N busy cycles. It is deasserted in the cycle where the new HI/LO become visible.
- Async reset mid-operation: busy drops immediately, the pending result is discarded, and HI/LO return to 0.
- A back-to-back MD op issues at the earliest in the first busy=0 cycle.

## Structure
- Shared header md_defs.vh holds:
  - the MD op encodings (MD_MULT … MD_MTLO);
  - state encodings (ST_IDLE=0, ST_BUSY=1);
  - the default cycle counts.
- The hazard unit decoder includes md_defs.vh to build md_use_D.
- One combinational sub-module, md_arith: inputs md_op, A, B; outputs res_hi, res_lo, div_zero. The md_scheduler top holds the FSM, counter, pend and HI/LO registers.

## Test plan
- MULT A=0xFFFFFFFD (-3), B=5 -> busy 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFF1; stall_md high for 6 cycles while md_use_D=1.
- DIVU A=100, B=7 -> after 10 busy cycles LO=14, HI=2. DIV A=-7, B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- MTLO A=0x12345678 in IDLE -> LO=0x12345678 next cycle, busy stays 0. Then DIV with B=0 -> 10 busy cycles, HI/LO unchanged.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF, with md_use_D=0 throughout -> stall_md stays 0. Result HI=0xFFFFFFFE, LO=0x00000001.
- Assert reset at busy cycle 3 of a DIV -> busy=0 and HI=LO=0 immediately. A following MULT 6x7 gives LO=42 after 5 cycles.
- start during BUSY -> ignored, assertion fires, and the original result commits on schedule.

Source files
------------

// File: rtl/md_scheduler_pkg.sv
// Shared definitions for the multiply/divide scheduler: op codes, FSM states,
// default busy-cycle counts and a small op-classification helper.
package md_scheduler_pkg;

   // Operation codes carried on md_op; 6 and 7 are reserved and ignored.
   localparam logic [2:0] MD_MULT  = 3'd0;
   localparam logic [2:0] MD_MULTU = 3'd1;
   localparam logic [2:0] MD_DIV   = 3'd2;
   localparam logic [2:0] MD_DIVU  = 3'd3;
   localparam logic [2:0] MD_MTHI  = 3'd4;
   localparam logic [2:0] MD_MTLO  = 3'd5;

   // Default busy-cycle counts.
   localparam int MD_MULT_CYCLES_DEF = 5;
   localparam int MD_DIV_CYCLES_DEF  = 10;

   // Scheduler FSM states.
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } md_state_e;

   // True for the ops that occupy the unit for several cycles.
   function automatic logic is_long_op(input logic [2:0] op);
      return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
   endfunction

   // True for the multiply ops (select MULT_CYCLES rather than DIV_CYCLES).
   function automatic logic is_mult_op(input logic [2:0] op);
      return (op == MD_MULT) || (op == MD_MULTU);
   endfunction

endpackage

// File: rtl/md_scheduler_arith.sv
// Combinational multiply/divide datapath. The result is produced in one
// evaluation; the scheduler only models the latency.
module md_arith
   import md_scheduler_pkg::*;
(
   input  logic [2:0]  md_op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic [31:0] res_hi,
   output logic [31:0] res_lo,
   output logic        div_zero
);

   logic [63:0] w_prod_s;
   logic [63:0] w_prod_u;
   logic [31:0] w_divisor;
   logic [31:0] w_quot_s;
   logic [31:0] w_rem_s;
   logic [31:0] w_quot_u;
   logic [31:0] w_rem_u;

   assign div_zero = ((md_op == MD_DIV) || (md_op == MD_DIVU)) && (B == 32'd0);

   // A zero divisor is replaced by 1 so the dividers never produce X;
   // the result is discarded anyway via div_zero.
   assign w_divisor = (B == 32'd0) ? 32'd1 : B;

   assign w_prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
   assign w_prod_u = {32'd0, A} * {32'd0, B};
   // Signed division truncates toward zero; remainder follows the dividend sign.
   assign w_quot_s = $signed(A) / $signed(w_divisor);
   assign w_rem_s  = $signed(A) % $signed(w_divisor);
   assign w_quot_u = A / w_divisor;
   assign w_rem_u  = A % w_divisor;

   // Select the HI/LO pair for the requested operation.
   always_comb begin
      res_hi = 32'd0;
      res_lo = 32'd0;
      case (md_op)
         MD_MULT:  begin res_hi = w_prod_s[63:32]; res_lo = w_prod_s[31:0]; end
         MD_MULTU: begin res_hi = w_prod_u[63:32]; res_lo = w_prod_u[31:0]; end
         MD_DIV:   begin res_hi = w_rem_s;         res_lo = w_quot_s;       end
         MD_DIVU:  begin res_hi = w_rem_u;         res_lo = w_quot_u;       end
         default:  begin res_hi = 32'd0;           res_lo = 32'd0;          end
      endcase
   end

endmodule

// File: rtl/md_scheduler.sv
// Multiply/divide scheduler: owns HI/LO, holds a computed result in pend
// registers for MULT_CYCLES/DIV_CYCLES cycles, and requests pipeline stalls
// for D-stage HI/LO users while busy.
//
// Handshake: start is a one-cycle command qualified by the E stage. It is
// accepted only in IDLE; the hazard unit keeps it low while busy (using
// stall_md), and a start seen while busy is dropped.
module md_scheduler
   import md_scheduler_pkg::*;
#(
   parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  md_op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        md_use_D,
   output logic        busy,
   output logic        stall_md,
   output logic [31:0] HI,
   output logic [31:0] LO,
   output md_state_e   dbg_state
);

   md_state_e   r_state;
   md_state_e   w_state_nx;
   logic [3:0]  r_cnt;
   logic [3:0]  w_cnt_nx;
   logic [31:0] r_hi;
   logic [31:0] r_lo;
   logic [31:0] r_pend_hi;
   logic [31:0] r_pend_lo;
   logic        r_pend_zero;
   logic        w_load;
   logic        w_commit;
   logic        w_long;
   logic        w_idle_start;
   logic [31:0] w_res_hi;
   logic [31:0] w_res_lo;
   logic        w_div_zero;

   md_arith u_arith (
      .md_op    (md_op),
      .A        (A),
      .B        (B),
      .res_hi   (w_res_hi),
      .res_lo   (w_res_lo),
      .div_zero (w_div_zero)
   );

   assign w_long       = is_long_op(md_op);
   assign w_idle_start = start && (r_state == ST_IDLE);

   // Next-state, counter and load/commit decode.
   always_comb begin
      w_state_nx = r_state;
      w_cnt_nx   = r_cnt;
      w_load     = 1'b0;
      w_commit   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start && w_long) begin
               w_load     = 1'b1;
               w_state_nx = ST_BUSY;
               w_cnt_nx   = is_mult_op(md_op) ? MULT_CYCLES[3:0] : DIV_CYCLES[3:0];
            end
         end
         ST_BUSY: begin
            if (r_cnt == 4'd1) begin
               w_commit   = 1'b1;
               w_cnt_nx   = 4'd0;
               w_state_nx = ST_IDLE;
            end else begin
               w_cnt_nx = r_cnt - 4'd1;
            end
         end
         default: begin
            w_state_nx = ST_IDLE;
            w_cnt_nx   = 4'd0;
         end
      endcase
   end

   // FSM state and cycle counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_cnt   <= 4'd0;
      end else begin
         r_state <= w_state_nx;
         r_cnt   <= w_cnt_nx;
      end
   end

   // Pending result captured when a long op is accepted.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pend_hi   <= 32'd0;
         r_pend_lo   <= 32'd0;
         r_pend_zero <= 1'b0;
      end else if (w_load) begin
         r_pend_hi   <= w_res_hi;
         r_pend_lo   <= w_res_lo;
         r_pend_zero <= w_div_zero;
      end
   end

   // HI/LO: written by a completing long op (unless divide by zero) or by MTHI/MTLO.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_hi <= 32'd0;
         r_lo <= 32'd0;
      end else if (w_commit) begin
         if (!r_pend_zero) begin
            r_hi <= r_pend_hi;
            r_lo <= r_pend_lo;
         end
      end else if (w_idle_start && (md_op == MD_MTHI)) begin
         r_hi <= A;
      end else if (w_idle_start && (md_op == MD_MTLO)) begin
         r_lo <= A;
      end
   end

   assign busy      = (r_state == ST_BUSY);
   assign stall_md  = md_use_D && (busy || (start && w_long));
   assign HI        = r_hi;
   assign LO        = r_lo;
   assign dbg_state = r_state;

   // The hazard unit must never issue while the unit is busy.
   a_no_start_busy: assert property (@(posedge clk) disable iff (reset)
      !(start && (r_state == ST_BUSY)))
      else $warning("md_scheduler: start while busy ignored");

endmodule
